// File: rtl/dlfloat_operand_loader.sv
// Byte-stream to DLFloat16 operand-pair loader: assembles LSB-first 4-byte frames,
// tags special values and queues pairs in a show-ahead FIFO with a byte-gap timeout.
module dlfloat_operand_loader #(
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [7:0]       in_byte,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [15:0]      op_a,
  output logic [15:0]      op_b,
  output logic [3:0]       op_flags,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [CNT_W-1:0] pair_count,
  output logic             frame_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] A_LO = 2'd0;
  localparam logic [1:0] A_HI = 2'd1;
  localparam logic [1:0] B_LO = 2'd2;
  localparam logic [1:0] B_HI = 2'd3;

  function automatic logic is_zero(input logic [15:0] x);
    return (x == 16'h0000);
  endfunction

  function automatic logic is_nan(input logic [15:0] x);
    return (x == 16'hFFFF);
  endfunction

  logic [1:0]       state_q, state_d;
  logic [7:0]       a_lo_q, a_lo_d, a_hi_q, a_hi_d, b_lo_q, b_lo_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [CNT_W-1:0] pair_count_q, pair_count_d;
  logic             frame_err_q, frame_err_d;
  logic [15:0]      mem_a_q [DEPTH];
  logic [15:0]      mem_a_d [DEPTH];
  logic [15:0]      mem_b_q [DEPTH];
  logic [15:0]      mem_b_d [DEPTH];
  logic [3:0]       mem_f_q [DEPTH];
  logic [3:0]       mem_f_d [DEPTH];

  logic        full_s, accept_s, push_s, pop_s;
  logic [15:0] a_word_s, b_word_s;

  // Handshake decode and head-of-FIFO presentation (zeros while empty).
  always_comb begin
    full_s   = (count_q == (AW+1)'(DEPTH));
    in_ready = !((state_q == B_HI) && full_s);
    op_valid = (count_q != '0);
    accept_s = in_valid && in_ready;
    push_s   = accept_s && (state_q == B_HI);
    pop_s    = op_valid && op_ready;
    a_word_s = {a_hi_q, a_lo_q};
    b_word_s = {in_byte, b_lo_q};
    if (op_valid) begin
      op_a     = mem_a_q[rd_ptr_q];
      op_b     = mem_b_q[rd_ptr_q];
      op_flags = mem_f_q[rd_ptr_q];
    end else begin
      op_a     = 16'h0000;
      op_b     = 16'h0000;
      op_flags = 4'b0000;
    end
    pair_count = pair_count_q;
    frame_err  = frame_err_q;
  end

  // Next-state logic: frame assembly, gap timer and FIFO bookkeeping; clr overrides all.
  always_comb begin
    state_d      = state_q;
    a_lo_d       = a_lo_q;
    a_hi_d       = a_hi_q;
    b_lo_d       = b_lo_q;
    timer_d      = timer_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    pair_count_d = pair_count_q;
    frame_err_d  = 1'b0;
    mem_a_d      = mem_a_q;
    mem_b_d      = mem_b_q;
    mem_f_d      = mem_f_q;
    if (clr) begin
      state_d      = A_LO;
      timer_d      = '0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      pair_count_d = '0;
    end else begin
      if (accept_s) begin
        timer_d = '0;
        case (state_q)
          A_LO:    begin a_lo_d = in_byte; state_d = A_HI; end
          A_HI:    begin a_hi_d = in_byte; state_d = B_LO; end
          B_LO:    begin b_lo_d = in_byte; state_d = B_HI; end
          B_HI:    state_d = A_LO;
          default: state_d = A_LO;
        endcase
      end else if (state_q == A_LO) begin
        timer_d = '0;
      end else if (in_valid) begin
        // Stalled by a full FIFO: not an upstream gap, so the timer holds.
        timer_d = timer_q;
      end else if (timer_q == TW'(TIMEOUT - 1)) begin
        timer_d     = '0;
        state_d     = A_LO;
        frame_err_d = 1'b1;
      end else begin
        timer_d = timer_q + TW'(1);
      end

      if (push_s) begin
        mem_a_d[wr_ptr_q] = a_word_s;
        mem_b_d[wr_ptr_q] = b_word_s;
        mem_f_d[wr_ptr_q] = {is_zero(a_word_s), is_nan(a_word_s),
                             is_zero(b_word_s), is_nan(b_word_s)};
        wr_ptr_d          = wr_ptr_q + AW'(1);
        pair_count_d      = pair_count_q + CNT_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end

      case ({push_s, pop_s})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= A_LO;
      a_lo_q       <= 8'h00;
      a_hi_q       <= 8'h00;
      b_lo_q       <= 8'h00;
      timer_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      pair_count_q <= '0;
      frame_err_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_a_q[i] <= 16'h0000;
        mem_b_q[i] <= 16'h0000;
        mem_f_q[i] <= 4'b0000;
      end
    end else begin
      state_q      <= state_d;
      a_lo_q       <= a_lo_d;
      a_hi_q       <= a_hi_d;
      b_lo_q       <= b_lo_d;
      timer_q      <= timer_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      pair_count_q <= pair_count_d;
      frame_err_q  <= frame_err_d;
      mem_a_q      <= mem_a_d;
      mem_b_q      <= mem_b_d;
      mem_f_q      <= mem_f_d;
    end
  end

endmodule

// File: tb/tb_dlfloat_operand_loader.sv
// Directed self-checking bench for dlfloat_operand_loader (DEPTH=2, TIMEOUT=16).
module tb_dlfloat_operand_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic [7:0]  in_byte = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] op_a, op_b;
  logic [3:0]  op_flags;
  logic        op_valid;
  logic        op_ready = 1'b0;
  logic [7:0]  pair_count;
  logic        frame_err;

  int checks = 0;
  int errors = 0;

  dlfloat_operand_loader #(.DEPTH(2), .TIMEOUT(16), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_byte(in_byte), .in_valid(in_valid),
    .in_ready(in_ready), .op_a(op_a), .op_b(op_b), .op_flags(op_flags),
    .op_valid(op_valid), .op_ready(op_ready), .pair_count(pair_count),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one byte and return 1ns after the edge that accepts it.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    in_byte  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check_eq("in_ready_wait", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_pair(input logic [7:0] b0, b1, b2, b3);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    send_byte(b3);
  endtask

  logic [15:0] exp_a [3];
  logic [15:0] exp_b [3];
  int k, pulses, pulse_at, stall_bad, head_bad, ferr_seen;
  logic accept_now;

  initial begin
    // Reset values
    #12;
    check_eq("rst_op_valid", op_valid, 1'b0);
    check_eq("rst_op_a", op_a, 16'h0000);
    check_eq("rst_pair_count", pair_count, 8'd0);
    check_eq("rst_frame_err", frame_err, 1'b0);
    check_eq("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic frame
    op_ready = 1'b1;
    send_pair(8'h00, 8'h3E, 8'h00, 8'h40);
    @(negedge clk);
    check_eq("basic_valid", op_valid, 1'b1);
    check_eq("basic_a", op_a, 16'h3E00);
    check_eq("basic_b", op_b, 16'h4000);
    check_eq("basic_flags", op_flags, 4'b0000);
    check_eq("basic_count", pair_count, 8'd1);
    @(negedge clk);
    check_eq("basic_popped", op_valid, 1'b0);

    // Special values
    op_ready = 1'b0;
    send_pair(8'h00, 8'h00, 8'hFF, 8'hFF);
    @(negedge clk);
    check_eq("spec_a", op_a, 16'h0000);
    check_eq("spec_b", op_b, 16'hFFFF);
    check_eq("spec_flags", op_flags, 4'b1001);
    op_ready = 1'b1;
    @(negedge clk);
    op_ready = 1'b0;
    check_eq("spec_popped", op_valid, 1'b0);

    // Timeout after two bytes: pulse on 16th idle edge, exactly once
    send_byte(8'h11);
    send_byte(8'h22);
    pulses = 0;
    pulse_at = 0;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if (frame_err) begin
        pulses++;
        if (pulse_at == 0) pulse_at = i;
      end
    end
    check_eq("to_pulses", pulses, 32'd1);
    check_eq("to_pulse_cycle", pulse_at, 32'd17);
    check_eq("to_no_push", op_valid, 1'b0);
    check_eq("to_count", pair_count, 8'd2);
    op_ready = 1'b1;
    send_pair(8'h00, 8'h3C, 8'h00, 8'h3C);
    @(negedge clk);
    check_eq("to_next_valid", op_valid, 1'b1);
    check_eq("to_next_a", op_a, 16'h3C00);
    check_eq("to_next_b", op_b, 16'h3C00);
    check_eq("to_next_count", pair_count, 8'd3);
    @(negedge clk);

    // clr with one entry queued and state B_LO
    op_ready = 1'b0;
    send_pair(8'h77, 8'h66, 8'h55, 8'h44);
    send_byte(8'h12);
    send_byte(8'h34);
    @(negedge clk);
    check_eq("clr_pre_count", pair_count, 8'd4);
    clr = 1'b1;
    in_valid = 1'b1;
    in_byte = 8'h99;
    op_ready = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    in_valid = 1'b0;
    op_ready = 1'b0;
    @(negedge clk);
    check_eq("clr_valid", op_valid, 1'b0);
    check_eq("clr_count", pair_count, 8'd0);
    check_eq("clr_frame_err", frame_err, 1'b0);
    send_pair(8'hAA, 8'hBB, 8'hCC, 8'hDD);
    @(negedge clk);
    check_eq("clr_fresh_a", op_a, 16'hBBAA);
    check_eq("clr_fresh_b", op_b, 16'hDDCC);
    check_eq("clr_fresh_count", pair_count, 8'd1);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;

    // Backpressure: three pairs into a two-entry FIFO
    exp_a[0] = 16'h1001; exp_b[0] = 16'h2002;
    exp_a[1] = 16'h3003; exp_b[1] = 16'h4004;
    exp_a[2] = 16'h5005; exp_b[2] = 16'h6006;
    send_pair(8'h01, 8'h10, 8'h02, 8'h20);
    send_pair(8'h03, 8'h30, 8'h04, 8'h40);
    send_byte(8'h05);
    send_byte(8'h50);
    send_byte(8'h06);
    @(negedge clk);
    in_byte = 8'h60;
    in_valid = 1'b1;
    stall_bad = 0;
    head_bad = 0;
    ferr_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) stall_bad++;
      if (op_a !== exp_a[0]) head_bad++;
      if (frame_err) ferr_seen++;
      @(negedge clk);
    end
    check_eq("bp_in_ready_low", stall_bad, 32'd0);
    check_eq("bp_head_held", head_bad, 32'd0);
    check_eq("bp_no_timeout", ferr_seen, 32'd0);
    check_eq("bp_count2", pair_count, 8'd2);
    k = 0;
    for (int i = 0; i < 6; i++) begin
      op_ready = 1'b1;
      if (op_valid) begin
        if (k < 3) begin
          check_eq("bp_drain_a", op_a, exp_a[k]);
          check_eq("bp_drain_b", op_b, exp_b[k]);
        end else begin
          check_eq("bp_extra_entry", op_a, 16'h0000);
        end
        k++;
      end
      accept_now = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (accept_now) in_valid = 1'b0;
      @(negedge clk);
    end
    op_ready = 1'b0;
    check_eq("bp_drained", k, 32'd3);
    check_eq("bp_count3", pair_count, 8'd3);

    // Asynchronous reset mid-frame with an entry queued
    send_pair(8'h01, 8'h02, 8'h03, 8'h04);
    send_byte(8'h09);
    send_byte(8'h08);
    @(negedge clk);
    check_eq("ar_pre_valid", op_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("ar_valid", op_valid, 1'b0);
    check_eq("ar_count", pair_count, 8'd0);
    check_eq("ar_op_a", op_a, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    send_pair(8'h0A, 8'h0B, 8'h0C, 8'h0D);
    @(negedge clk);
    check_eq("ar_fresh_a", op_a, 16'h0B0A);
    check_eq("ar_fresh_b", op_b, 16'h0D0C);
    check_eq("ar_fresh_count", pair_count, 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
